// File: rtl/eqs_mul_shadd32u.sv
// eqs_mul_shadd32u: sequential radix-2 shift-add unsigned multiplier
// with early exit on exhausted multiplier bits and a combinational zero bypass.
module eqs_mul_shadd32u #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    input  logic               start_in,
    output logic [2*WIDTH-1:0] p_out,
    output logic               busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {FINISH = 2'd0, PREP = 2'd1, LOOP = 2'd2, FREE = 2'd3} state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      count_q, count_d;
    logic               zero, last;

    assign zero  = (a_in == '0) || (b_in == '0);
    assign busy  = (state_q == PREP) || (state_q == LOOP);
    assign p_out = zero ? '0 : acc_q;
    // Stop once only bit 0 of the multiplier remains to be consumed
    assign last  = ((mplier_q >> 1) == '0) || (count_q == CW'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        case (state_q)
            PREP: begin
                state_d  = LOOP;
                acc_d    = '0;
                mcand_d  = {{WIDTH{1'b0}}, a_in};
                mplier_d = b_in;
                count_d  = '0;
            end
            LOOP: begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                state_d  = last ? FINISH : LOOP;
            end
            default: state_d = (start_in && !zero) ? PREP : FINISH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FINISH;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_eqs_mul_shadd32u.sv
// tb_eqs_mul_shadd32u: randomized bench with a cycle-level behavioural model
// of the multiplier (product, busy length) plus directed literal checks.
module tb_eqs_mul_shadd32u;
    logic        clk, rst, start_in, busy;
    logic [31:0] a_in, b_in;
    logic [63:0] p_out;
    int          tests = 0, fails = 0;
    int          rem = 0;
    logic [63:0] prod = '0;

    eqs_mul_shadd32u #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in),
        .start_in(start_in), .p_out(p_out), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int msb(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Model: an accepted op stays busy for msb(b)+2 cycles and yields a*b
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rem  <= 0;
            prod <= '0;
        end else if (rem > 0) begin
            rem <= rem - 1;
        end else if (start_in && a_in != 0 && b_in != 0) begin
            rem  <= msb(b_in) + 2;
            prod <= 64'(a_in) * 64'(b_in);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("cycle_busy", 64'(busy), 64'(rem > 0));
            if (rem == 0)
                check("cycle_p", p_out, (a_in == 0 || b_in == 0) ? 64'd0 : prod);
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int cyc);
        @(posedge clk); #2;
        a_in = a; b_in = b; start_in = 1'b1;
        @(posedge clk); #2;
        start_in = 1'b0;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(posedge clk); #2;
        end
        if (cyc >= 100) check("busy_timeout", 64'(busy), 64'd0);
    endtask

    initial begin
        int cyc;
        logic [31:0] ra, rb;
        rst = 1'b1; a_in = '0; b_in = '0; start_in = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_p", p_out, 64'd0);
        rst = 1'b0;

        run_op(32'd3, 32'd5, cyc);
        check("t2_cycles", 64'(cyc), 64'd4);
        check("t2_p", p_out, 64'd15);
        repeat (10) @(posedge clk);
        #2;
        check("t2_hold", p_out, 64'd15);

        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("t1_busy", 64'(busy), 64'd0);
        check("t1_p", p_out, 64'd0);
        rst = 1'b0;

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
        check("t3_cycles", 64'(cyc), 64'd33);
        check("t3_p", p_out, 64'hFFFF_FFFE_0000_0001);

        @(posedge clk); #2;
        a_in = 32'h1234; b_in = 32'd0; start_in = 1'b1;
        #1;
        check("t4_p_b0", p_out, 64'd0);
        @(posedge clk); #2;
        check("t4_busy_b0", 64'(busy), 64'd0);
        a_in = 32'd0; b_in = 32'd7;
        #1;
        check("t4_p_a0", p_out, 64'd0);
        @(posedge clk); #2;
        check("t4_busy_a0", 64'(busy), 64'd0);
        start_in = 1'b0;

        @(posedge clk); #2;
        a_in = 32'h8000_0000; b_in = 32'd1; start_in = 1'b1;
        @(posedge clk); #2;
        check("t5_busy", 64'(busy), 64'd1);
        @(posedge clk); #2;
        start_in = 1'b0;
        check("t5_busy2", 64'(busy), 64'd1);
        @(posedge clk); #2;
        check("t5_done", 64'(busy), 64'd0);
        check("t5_p", p_out, 64'h0000_0000_8000_0000);
        @(posedge clk); #2;
        check("t5_no_restart", 64'(busy), 64'd0);

        @(posedge clk); #2;
        a_in = 32'd9; b_in = 32'h8000_0000; start_in = 1'b1;
        @(posedge clk); #2;
        start_in = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t6_abort_busy", 64'(busy), 64'd0);
        check("t6_abort_p", p_out, 64'd0);
        rst = 1'b0;
        run_op(32'd7, 32'd6, cyc);
        check("t6_cycles", 64'(cyc), 64'd4);
        check("t6_p", p_out, 64'd42);

        for (int i = 0; i < 60; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            run_op(ra, rb, cyc);
            check("rand_cycles", 64'(cyc), (ra == 0 || rb == 0) ? 64'd0 : 64'(msb(rb) + 2));
            check("rand_p", p_out, 64'(ra) * 64'(rb));
        end

        for (int i = 0; i < 800; i++) begin
            @(posedge clk); #2;
            if (!busy) begin
                a_in = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
                b_in = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            end
            start_in = 1'($urandom_range(0, 1));
        end
        start_in = 1'b0;
        repeat (40) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
